// File: rtl/sd_bridge_pkg.sv
// Shared types and sizes for the SD sector bridge and its sector buffer.
package sd_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StXfer,
    StFinish
  } state_e;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SD_ADDR_W    = 9;
  localparam int unsigned CNT_W        = 10;

endpackage

// File: rtl/sd_sector_ram.sv
// 512-byte sector buffer as even/odd 256x8 banks: byte port for the card, word port for the host.
module sd_sector_ram
  import sd_bridge_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SD_ADDR_W-1:0] a_addr_i,
  input  logic                 a_we_i,
  input  logic [7:0]           a_wdata_i,
  output logic [7:0]           a_rdata_o,
  input  logic [7:0]           b_addr_i,
  input  logic [1:0]           b_be_i,
  input  logic                 b_we_i,
  input  logic [15:0]          b_wdata_i,
  output logic [15:0]          b_rdata_o
);

  logic [7:0]  mem_even [256];
  logic [7:0]  mem_odd  [256];
  logic [7:0]  a_idx;
  logic [7:0]  a_even_d, a_even_q, a_odd_d, a_odd_q;
  logic        a_sel_d, a_sel_q;
  logic [15:0] b_rdata_d, b_rdata_q;

  assign a_idx = a_addr_i[8:1];

  // Even byte (big-endian high byte) lives at address bit 0 == 0.
  always_ff @(posedge clk_i) begin
    if (a_we_i && !a_addr_i[0]) mem_even[a_idx] <= a_wdata_i;
    if (b_we_i && b_be_i[1])    mem_even[b_addr_i] <= b_wdata_i[15:8];
  end

  always_ff @(posedge clk_i) begin
    if (a_we_i && a_addr_i[0]) mem_odd[a_idx] <= a_wdata_i;
    if (b_we_i && b_be_i[0])   mem_odd[b_addr_i] <= b_wdata_i[7:0];
  end

  always_comb begin
    a_even_d  = mem_even[a_idx];
    a_odd_d   = mem_odd[a_idx];
    a_sel_d   = a_addr_i[0];
    b_rdata_d = {mem_even[b_addr_i], mem_odd[b_addr_i]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_even_q  <= '0;
      a_odd_q   <= '0;
      a_sel_q   <= 1'b0;
      b_rdata_q <= '0;
    end else begin
      a_even_q  <= a_even_d;
      a_odd_q   <= a_odd_d;
      a_sel_q   <= a_sel_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata_o = a_sel_q ? a_odd_q : a_even_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/sd_sector_bridge.sv
// Single-sector request sequencer in front of sd_rw, with a host-visible 512-byte buffer.
module sd_sector_bridge
  import sd_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [31:0]          req_lba,
  output logic                 req_ready,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  input  logic [7:0]           host_addr,
  input  logic [1:0]           host_be,
  input  logic                 host_we,
  input  logic [15:0]          host_wdata,
  output logic [15:0]          host_rdata,
  output logic                 sd_rstart,
  output logic                 sd_wstart,
  output logic [31:0]          sd_sector,
  input  logic                 sd_rbusy,
  input  logic                 sd_rdone,
  input  logic                 sd_outen,
  input  logic [SD_ADDR_W-1:0] sd_outaddr,
  input  logic [7:0]           sd_outbyte,
  output logic [7:0]           sd_inbyte
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_d, state_q;
  logic              write_d, write_q;
  logic [31:0]       sector_d, sector_q;
  logic              rstart_d, rstart_q;
  logic              wstart_d, wstart_q;
  logic              err_d, err_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [TmoW-1:0]   tmo_d, tmo_q;
  logic              host_we_idle;

  assign req_ready = (state_q == StIdle) && !sd_rbusy;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    sector_d = sector_q;
    rstart_d = rstart_q;
    wstart_d = wstart_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          sector_d = req_lba;
          write_d  = req_write;
          rstart_d = !req_write;
          wstart_d = req_write;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        // sd_rw only samples start while ready, so holding it until rbusy is safe.
        if (sd_rbusy) begin
          rstart_d = 1'b0;
          wstart_d = 1'b0;
          state_d  = StXfer;
        end
      end
      StXfer: begin
        if (sd_outen && !write_q) cnt_d = cnt_q + CNT_W'(1);
        tmo_d = tmo_q + TmoW'(1);
        // rdone takes priority over both error exits, including a same-cycle timeout.
        if (sd_rdone) begin
          err_d   = !write_q && (cnt_d != CNT_W'(SECTOR_BYTES));
          state_d = StFinish;
        end else if (!sd_rbusy) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      sector_q <= '0;
      rstart_q <= 1'b0;
      wstart_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      sector_q <= sector_d;
      rstart_q <= rstart_d;
      wstart_q <= wstart_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFinish);
  assign err       = done && err_q;
  assign sd_rstart = rstart_q;
  assign sd_wstart = wstart_q;
  assign sd_sector = sector_q;

  // Host writes land only while no transfer owns the buffer.
  assign host_we_idle = host_we && (state_q == StIdle);

  sd_sector_ram u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_addr_i  (sd_outaddr),
    .a_we_i    (sd_outen),
    .a_wdata_i (sd_outbyte),
    .a_rdata_o (sd_inbyte),
    .b_addr_i  (host_addr),
    .b_be_i    (host_be),
    .b_we_i    (host_we_idle),
    .b_wdata_i (host_wdata),
    .b_rdata_o (host_rdata)
  );

endmodule
